// File: rtl/credit_pkg.sv
// Shared state encoding for the credit-based flow-control link (creditor and link wrapper).
package credit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } credit_state_e;

endpackage

// File: rtl/creditor_if.sv
// Credit link port bundle: credit return/consumption events plus the tranche offer handshake.
interface creditor_if #(
  parameter int unsigned TRANCHE_WIDTH = 3
);

  logic                     payback;
  logic                     free;
  logic                     lend;
  logic [TRANCHE_WIDTH-1:0] tranche;
  logic                     lend_ack;
  logic                     error;

  // Creditor side: owns the offer and the error pulse.
  modport master (
    input  payback,
    input  free,
    input  lend_ack,
    output lend,
    output tranche,
    output error
  );

  // Link side: reports received/popped words and accepts offers.
  modport slave (
    output payback,
    output free,
    output lend_ack,
    input  lend,
    input  tranche,
    input  error
  );

endinterface

// File: rtl/creditor.sv
// Downstream credit owner: tracks outstanding/occupied slots and offers credit tranches.
// Optional partial-tranche timeout is enabled by defining CREDITOR_TIMEOUT_EN.
module creditor
  import credit_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned TRANCHE_WIDTH = 3,
  parameter int unsigned CAPACITY      = 8,
  parameter int unsigned MIN_TRANCHE   = 4,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic       clk,
  input  logic       rst,
  creditor_if.master bus
);

  localparam int unsigned AW   = WIDTH + 1;
  localparam int unsigned TMAX = (1 << TRANCHE_WIDTH) - 1;

  credit_state_e            state;
  logic [WIDTH-1:0]         outstanding;
  logic [WIDTH-1:0]         occupied;
  logic [AW-1:0]            available;
  logic [WIDTH-1:0]         outstanding_nxt;
  logic [WIDTH-1:0]         occupied_nxt;
  logic [TRANCHE_WIDTH-1:0] grant;
  logic                     pb_ok, pb_err, fr_ok, fr_err, take, offer_ok;
  logic                     expire;

  // Event legality and the combined counter update; illegal parts are simply dropped.
  always_comb begin
    available       = AW'(CAPACITY) - AW'(outstanding) - AW'(occupied);
    pb_ok           = bus.payback && (outstanding != '0);
    pb_err          = bus.payback && (outstanding == '0);
    fr_ok           = bus.free && (occupied != '0);
    fr_err          = bus.free && (occupied == '0);
    take            = (state == OFFER) && bus.lend_ack;
    outstanding_nxt = outstanding + (take ? WIDTH'(bus.tranche) : WIDTH'(0)) - WIDTH'(pb_ok);
    occupied_nxt    = occupied + WIDTH'(pb_ok) - WIDTH'(fr_ok);
    offer_ok        = available >= AW'(MIN_TRANCHE);
    grant           = (available >= AW'(TMAX)) ? TRANCHE_WIDTH'(TMAX)
                                               : TRANCHE_WIDTH'(available);
  end

`ifdef CREDITOR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          partial;

  assign partial = (available != '0) && !offer_ok;
  assign expire  = (state == IDLE) && partial && (idle_cnt == TW'(TIMEOUT - 1));

  // Counts consecutive IDLE cycles with a small but non-zero free window.
  always_ff @(posedge clk) begin
    if (rst || (state != IDLE) || !partial || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Offer FSM and accounting registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= '0;
      occupied    <= '0;
      bus.lend    <= 1'b0;
      bus.tranche <= '0;
      bus.error   <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      occupied    <= occupied_nxt;
      bus.error   <= pb_err || fr_err;
      case (state)
        IDLE: begin
          if (offer_ok) begin
            bus.tranche <= grant;
            bus.lend    <= 1'b1;
            state       <= OFFER;
          end else if (expire) begin
            bus.tranche <= TRANCHE_WIDTH'(available);
            bus.lend    <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (bus.lend_ack) begin
            bus.lend <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_creditor.sv
// Directed bench for creditor (WIDTH=4, TRANCHE_WIDTH=3, CAPACITY=8, MIN_TRANCHE=4, TIMEOUT=16).
module tb_creditor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic seen;

  creditor_if #(.TRANCHE_WIDTH(3)) bus ();

  creditor #(
    .WIDTH(4),
    .TRANCHE_WIDTH(3),
    .CAPACITY(8),
    .MIN_TRANCHE(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    seen        = 1'b0;
    rst         = 1'b1;
    bus.payback = 1'b0;
    bus.free    = 1'b0;
    bus.lend_ack = 1'b0;
    step();
    step();
    chk("rst_lend", 32'(bus.lend), 0);
    chk("rst_tranche", 32'(bus.tranche), 0);
    chk("rst_error", 32'(bus.error), 0);
    chk("rst_outstanding", 32'(dut.outstanding), 0);
    chk("rst_occupied", 32'(dut.occupied), 0);

    // First offer after reset, with an illegal free on the same edge.
    rst = 1'b0; bus.free = 1'b1;
    step();
    bus.free = 1'b0;
    chk("first_lend", 32'(bus.lend), 1);
    chk("first_tranche", 32'(bus.tranche), 7);
    chk("free_underflow_err", 32'(bus.error), 1);
    chk("free_underflow_occ", 32'(dut.occupied), 0);

    bus.lend_ack = 1'b1;
    step();
    bus.lend_ack = 1'b0;
    chk("ack_err_clear", 32'(bus.error), 0);
    chk("ack_lend_drop", 32'(bus.lend), 0);
    chk("ack_outstanding", 32'(dut.outstanding), 7);
    step();
    step();
    chk("avail1_no_offer", 32'(bus.lend), 0);

    bus.payback = 1'b1;
    repeat (7) step();
    bus.payback = 1'b0;
    chk("pb7_outstanding", 32'(dut.outstanding), 0);
    chk("pb7_occupied", 32'(dut.occupied), 7);
    chk("pb7_lend", 32'(bus.lend), 0);

    bus.payback = 1'b1;
    step();
    bus.payback = 1'b0;
    chk("pb_underflow_err", 32'(bus.error), 1);
    chk("pb_underflow_out", 32'(dut.outstanding), 0);
    chk("pb_underflow_occ", 32'(dut.occupied), 7);
    step();
    chk("pb_err_one_cycle", 32'(bus.error), 0);

    bus.free = 1'b1;
    repeat (3) step();
    bus.free = 1'b0;
    chk("free3_occupied", 32'(dut.occupied), 4);
    chk("free3_no_lend_yet", 32'(bus.lend), 0);
    step();
    chk("offer4_lend", 32'(bus.lend), 1);
    chk("offer4_tranche", 32'(bus.tranche), 4);

    // Hold the offer five cycles without ack while two words are popped.
    bus.free = 1'b1;
    repeat (2) step();
    bus.free = 1'b0;
    repeat (3) step();
    chk("hold_lend", 32'(bus.lend), 1);
    chk("hold_tranche", 32'(bus.tranche), 4);
    chk("hold_occupied", 32'(dut.occupied), 2);

    bus.lend_ack = 1'b1;
    step();
    bus.lend_ack = 1'b0;
    chk("ack2_lend", 32'(bus.lend), 0);
    chk("ack2_outstanding", 32'(dut.outstanding), 4);

    bus.payback = 1'b1; bus.free = 1'b1;
    step();
    bus.payback = 1'b0;
    chk("pb_free_out", 32'(dut.outstanding), 3);
    chk("pb_free_occ", 32'(dut.occupied), 2);
    chk("pb_free_err", 32'(bus.error), 0);
    step();
    bus.free = 1'b0;
    chk("free_occ1", 32'(dut.occupied), 1);
    chk("free_occ1_lend", 32'(bus.lend), 0);
    step();
    chk("offer3_lend", 32'(bus.lend), 1);
    chk("offer3_tranche", 32'(bus.tranche), 4);

    bus.lend_ack = 1'b1; bus.payback = 1'b1;
    step();
    bus.lend_ack = 1'b0; bus.payback = 1'b0;
    chk("ack_pb_out", 32'(dut.outstanding), 6);
    chk("ack_pb_occ", 32'(dut.occupied), 2);
    chk("ack_pb_err", 32'(bus.error), 0);
    chk("ack_pb_lend", 32'(bus.lend), 0);

    // Leave exactly two free slots: below MIN_TRANCHE but non-zero.
    bus.payback = 1'b1;
    repeat (2) step();
    bus.payback = 1'b0;
    bus.free = 1'b1;
    repeat (2) step();
    bus.free = 1'b0;
    chk("partial_out", 32'(dut.outstanding), 4);
    chk("partial_occ", 32'(dut.occupied), 2);

`ifdef CREDITOR_TIMEOUT_EN
    repeat (14) step();
    chk("timeout_not_yet", 32'(bus.lend), 0);
    step();
    chk("timeout_lend", 32'(bus.lend), 1);
    chk("timeout_tranche", 32'(bus.tranche), 2);
`else
    repeat (100) begin
      step();
      if (bus.lend) seen = 1'b1;
    end
    chk("no_partial_offer", 32'(seen), 0);
`endif

    rst = 1'b1;
    step();
    chk("rst2_lend", 32'(bus.lend), 0);
    chk("rst2_outstanding", 32'(dut.outstanding), 0);
    chk("rst2_occupied", 32'(dut.occupied), 0);
    rst = 1'b0;
    step();
    chk("rerelease_lend", 32'(bus.lend), 1);
    chk("rerelease_tranche", 32'(bus.tranche), 7);
    rst = 1'b1;
    step();
    chk("rst_in_offer_lend", 32'(bus.lend), 0);
    chk("rst_in_offer_tranche", 32'(bus.tranche), 0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
